debug_clk_gen: RTL

Multi-channel debug clock generator for the debug subsystem. It produces per-channel divided clocks from the system clock, with four modes: stopped, free-running, single-step on a pulse, and burst of N periods on a pulse. The external pulse input is asynchronous and is synchronized and edge-detected internally. Outputs drive core clock-enable or gated-clock logic under debugger control.

---
 rtl/debug_clk_pkg.sv | 19 +
 rtl/debug_clk_channel.sv | 148 ++++++++++++++
 rtl/debug_clk_gen.sv | 64 ++++++
 3 files changed

// File: rtl/debug_clk_pkg.sv
// Shared definitions for the debug clock generator: mode encodings,
// per-channel FSM state type and the minimum usable divider.
package debug_clk_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // A period needs at least one high and one low cycle.
  localparam int unsigned MIN_DIVIDER = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/debug_clk_channel.sv
// One debug clock channel: IDLE/HIGH/LOW FSM, phase counter, divider latch
// and (with DEBUG_CLK_BURST_EN defined) the burst period counter. Without
// DEBUG_CLK_BURST_EN, mode 11 behaves as STEP and burst_len is ignored.
module debug_clk_channel
  import debug_clk_pkg::*;
#(
  parameter int COUNTER_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig,
  input  logic [1:0]              mode,
  input  logic [COUNTER_BITS-1:0] divider,
  input  logic [COUNTER_BITS-1:0] burst_len,
  output logic                    clk_o,
  output logic                    busy_o,
  output logic                    tick_o
);

  localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);

  state_e                  state_q, state_d;
  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic [COUNTER_BITS-1:0] div_q, div_d;
  logic                    clk_q, clk_d;
  logic                    busy_q, busy_d;
  logic                    tick_q, tick_d;
  logic [COUNTER_BITS-1:0] new_div;
  logic                    start;
`ifdef DEBUG_CLK_BURST_EN
  logic [COUNTER_BITS-1:0] rem_q, rem_d;
`else
  logic                    unused_burst_len;
  assign unused_burst_len = ^burst_len;
`endif

  // Clamp the requested period to the minimum of one high and one low cycle.
  function automatic logic [COUNTER_BITS-1:0] eff_div(input logic [COUNTER_BITS-1:0] d);
    return (d < COUNTER_BITS'(MIN_DIVIDER)) ? COUNTER_BITS'(MIN_DIVIDER) : d;
  endfunction

  assign new_div = eff_div(divider);

  // Next-state, counter loads and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    start   = 1'b0;
`ifdef DEBUG_CLK_BURST_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_FREE) begin
          start = 1'b1;
`ifdef DEBUG_CLK_BURST_EN
          rem_d = '0;
`endif
        end else if (trig && mode == MODE_STEP) begin
          start = 1'b1;
`ifdef DEBUG_CLK_BURST_EN
          rem_d = ONE;
`endif
        end else if (trig && mode == MODE_BURST) begin
`ifdef DEBUG_CLK_BURST_EN
          if (burst_len != '0) begin
            start = 1'b1;
            rem_d = burst_len;
          end
`else
          start = 1'b1;
`endif
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = (div_q - (div_q >> 1)) - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (mode == MODE_FREE) begin
            start = 1'b1;
`ifdef DEBUG_CLK_BURST_EN
          end else if (rem_q > ONE) begin
            start = 1'b1;
            rem_d = rem_q - ONE;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new period latches the divider so mid-period changes wait for the boundary.
    if (start) begin
      state_d = ST_HIGH;
      div_d   = new_div;
      cnt_d   = (new_div >> 1) - ONE;
    end
    if (mode == MODE_STOP) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
`ifdef DEBUG_CLK_BURST_EN
      rem_d   = '0;
`endif
    end
    clk_d  = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
    tick_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  end

  // Control state and registered outputs, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  // Counters and divider latch; always reloaded before use, so no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    div_q <= div_d;
`ifdef DEBUG_CLK_BURST_EN
    rem_q <= rem_d;
`endif
  end

  assign clk_o  = clk_q;
  assign busy_o = busy_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/debug_clk_gen.sv
// Multi-channel debug clock generator top: synchronizes and edge-detects
// the asynchronous pulse, fans the trigger out to CHANNELS channels and
// gates each registered clock with its enable.
// Optional feature macro: DEBUG_CLK_BURST_EN (multi-period BURST mode).
module debug_clk_gen
  import debug_clk_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int COUNTER_BITS = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CHANNELS-1:0]              enable,
  input  logic [2*CHANNELS-1:0]            mode,
  input  logic [CHANNELS*COUNTER_BITS-1:0] divider,
  input  logic [COUNTER_BITS-1:0]          burst_len,
  input  logic                             pulse,
  output logic [CHANNELS-1:0]              clk_o,
  output logic [CHANNELS-1:0]              busy,
  output logic [CHANNELS-1:0]              tick_o
);

  // [0],[1] form the two-flop synchronizer, [2] holds the previous value.
  logic [2:0]          sync_q, sync_d;
  logic                trig;
  logic [CHANNELS-1:0] ch_clk;

  // Shift the pulse through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[1:0], pulse};
  end

  // Synchronizer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Rising edge only; falling edges produce nothing.
  assign trig = sync_q[1] & ~sync_q[2];

  for (genvar g = 0; g < CHANNELS; g++) begin : gen_ch
    debug_clk_channel #(
      .COUNTER_BITS(COUNTER_BITS)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .trig     (trig),
      .mode     (mode[2*g +: 2]),
      .divider  (divider[g*COUNTER_BITS +: COUNTER_BITS]),
      .burst_len(burst_len),
      .clk_o    (ch_clk[g]),
      .busy_o   (busy[g]),
      .tick_o   (tick_o[g])
    );
  end

  // Enable only masks the output; channel timing is unaffected.
  assign clk_o = ch_clk & enable;

endmodule
